// File: rtl/crc_check.sv
// ---------------------------------------------------------------------------
// crc_check
//   Serial CRC-8 checker, receive-side partner of the serial CRC generator.
//   A frame is a run of data bits (DATA_EN) followed by the 8 transmitted CRC
//   bits (CRC_EN, LSB of the LFSR first). The data bits are run through the
//   same LFSR as the generator. Each CRC bit is then compared against LFSR[0]
//   while the LFSR shifts out. The result is reported as pass, CRC mismatch or
//   length/protocol error.
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   asynchronous, active-low reset
//   SER_IN    in   serial bit (data or CRC)
//   DATA_EN   in   SER_IN carries a data bit this cycle (wins over CRC_EN)
//   CRC_EN    in   SER_IN carries a CRC bit this cycle
//   BUSY      out  frame in progress (DATA or CHECK)
//   DONE      out  one-cycle pulse: result flags / DATA_CNT updated
//   CRC_OK    out  last frame passed
//   CRC_ERR   out  last frame had at least one CRC bit mismatch
//   LEN_ERR   out  last frame too long, aborted or timed out
//   DATA_CNT  out  data bits in last frame, saturating at 63
// ---------------------------------------------------------------------------
module crc_check #(
  parameter logic [7:0] TAPS     = 8'h44,
  parameter logic [7:0] SEED     = 8'hD8,
  parameter int         MAX_BITS = 32,
  parameter int         TIMEOUT  = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SER_IN,
  input  logic       DATA_EN,
  input  logic       CRC_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic       CRC_OK,
  output logic       CRC_ERR,
  output logic       LEN_ERR,
  output logic [5:0] DATA_CNT
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK} state_t;

  state_t          r_state;
  logic [7:0]      r_lfsr;
  logic [5:0]      r_dcnt;
  logic [2:0]      r_ccnt;
  logic [IW-1:0]   r_icnt;
  logic            r_mis;
  logic            r_busy;
  logic            r_done;
  logic            r_ok;
  logic            r_crc_err;
  logic            r_len_err;
  logic [5:0]      r_data_cnt;

  state_t          w_state_nxt;
  logic [7:0]      w_lfsr_nxt;
  logic [5:0]      w_dcnt_nxt;
  logic [2:0]      w_ccnt_nxt;
  logic [IW-1:0]   w_icnt_nxt;
  logic            w_mis_nxt;
  logic            w_done_nxt;
  logic            w_ok_nxt;
  logic            w_crc_err_nxt;
  logic            w_len_err_nxt;
  logic [5:0]      w_data_cnt_nxt;
  logic            w_go_idle;
  logic            w_mis_bit;
  logic            w_timeout;
  logic            w_len_over;

  // One LFSR step for an accepted data bit.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
    logic [7:0] n;
    logic       fb;
    fb   = d ^ l[0];
    n[7] = fb;
    for (int i = 0; i < 7; i++) n[i] = l[i+1] ^ (TAPS[i] & fb);
    return n;
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == 6'h3F) ? c : c + 6'd1;
  endfunction

  // The idle counter sits at TIMEOUT-1 when the current empty cycle is the
  // TIMEOUT-th consecutive one.
  assign w_timeout  = (r_icnt == IW'(TIMEOUT - 1));
  assign w_len_over = (int'(r_dcnt) > MAX_BITS);
  assign w_mis_bit  = r_mis | (SER_IN ^ r_lfsr[0]);

  always_comb begin
    w_state_nxt    = r_state;
    w_lfsr_nxt     = r_lfsr;
    w_dcnt_nxt     = r_dcnt;
    w_ccnt_nxt     = r_ccnt;
    w_icnt_nxt     = r_icnt;
    w_mis_nxt      = r_mis;
    w_done_nxt     = 1'b0;
    w_ok_nxt       = r_ok;
    w_crc_err_nxt  = r_crc_err;
    w_len_err_nxt  = r_len_err;
    w_data_cnt_nxt = r_data_cnt;
    w_go_idle      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_lfsr_nxt = SEED;
        w_dcnt_nxt = 6'd0;
        w_ccnt_nxt = 3'd0;
        w_icnt_nxt = '0;
        w_mis_nxt  = 1'b0;
        // A lone CRC_EN in IDLE is stray link noise and is ignored.
        if (DATA_EN) begin
          w_lfsr_nxt  = lfsr_step(SEED, SER_IN);
          w_dcnt_nxt  = 6'd1;
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (DATA_EN) begin
          w_lfsr_nxt = lfsr_step(r_lfsr, SER_IN);
          w_dcnt_nxt = sat_inc(r_dcnt);
          w_icnt_nxt = '0;
        end else if (CRC_EN) begin
          w_mis_nxt   = SER_IN ^ r_lfsr[0];
          w_lfsr_nxt  = {1'b0, r_lfsr[7:1]};
          w_ccnt_nxt  = 3'd1;
          w_icnt_nxt  = '0;
          w_state_nxt = S_CHECK;
        end else if (w_timeout) begin
          w_done_nxt     = 1'b1;
          w_ok_nxt       = 1'b0;
          w_crc_err_nxt  = 1'b0;
          w_len_err_nxt  = 1'b1;
          w_data_cnt_nxt = r_dcnt;
          w_go_idle      = 1'b1;
        end else begin
          w_icnt_nxt = r_icnt + 1'b1;
        end
      end

      S_CHECK: begin
        if (DATA_EN) begin
          // Data inside the CRC field: abort; the offending bit is dropped.
          w_done_nxt     = 1'b1;
          w_ok_nxt       = 1'b0;
          w_crc_err_nxt  = r_mis;
          w_len_err_nxt  = 1'b1;
          w_data_cnt_nxt = r_dcnt;
          w_go_idle      = 1'b1;
        end else if (CRC_EN) begin
          w_mis_nxt  = w_mis_bit;
          w_lfsr_nxt = {1'b0, r_lfsr[7:1]};
          w_icnt_nxt = '0;
          if (r_ccnt == 3'd7) begin
            w_done_nxt     = 1'b1;
            w_crc_err_nxt  = w_mis_bit;
            w_len_err_nxt  = w_len_over;
            w_ok_nxt       = ~w_mis_bit & ~w_len_over;
            w_data_cnt_nxt = r_dcnt;
            w_go_idle      = 1'b1;
          end else begin
            w_ccnt_nxt = r_ccnt + 3'd1;
          end
        end else if (w_timeout) begin
          w_done_nxt     = 1'b1;
          w_ok_nxt       = 1'b0;
          w_crc_err_nxt  = 1'b0;
          w_len_err_nxt  = 1'b1;
          w_data_cnt_nxt = r_dcnt;
          w_go_idle      = 1'b1;
        end else begin
          w_icnt_nxt = r_icnt + 1'b1;
        end
      end

      default: w_go_idle = 1'b1;
    endcase

    if (w_go_idle) begin
      w_state_nxt = S_IDLE;
      w_lfsr_nxt  = SEED;
      w_dcnt_nxt  = 6'd0;
      w_ccnt_nxt  = 3'd0;
      w_icnt_nxt  = '0;
      w_mis_nxt   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_dcnt     <= 6'd0;
      r_ccnt     <= 3'd0;
      r_icnt     <= '0;
      r_mis      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_crc_err  <= 1'b0;
      r_len_err  <= 1'b0;
      r_data_cnt <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_ccnt     <= w_ccnt_nxt;
      r_icnt     <= w_icnt_nxt;
      r_mis      <= w_mis_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      r_ok       <= w_ok_nxt;
      r_crc_err  <= w_crc_err_nxt;
      r_len_err  <= w_len_err_nxt;
      r_data_cnt <= w_data_cnt_nxt;
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign CRC_OK   = r_ok;
  assign CRC_ERR  = r_crc_err;
  assign LEN_ERR  = r_len_err;
  assign DATA_CNT = r_data_cnt;

endmodule

// File: tb/tb_crc_check.sv
// ---------------------------------------------------------------------------
// tb_crc_check
//   Bench for crc_check: table of whole frames plus hand-built sequences for
//   abort, timeout, priority, reset and back-to-back cases. Expected results
//   are queued when the deciding bit is driven and popped when DONE appears.
// ---------------------------------------------------------------------------
module tb_crc_check;

  localparam logic [7:0] TAPS = 8'h44;
  localparam logic [7:0] SEED = 8'hD8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SER_IN = 1'b0;
  logic       DATA_EN = 1'b0;
  logic       CRC_EN = 1'b0;
  logic       BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR;
  logic [5:0] DATA_CNT;

  crc_check dut (
    .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .DATA_EN(DATA_EN), .CRC_EN(CRC_EN),
    .BUSY(BUSY), .DONE(DONE), .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR),
    .LEN_ERR(LEN_ERR), .DATA_CNT(DATA_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ok;
    logic       cerr;
    logic       lerr;
    logic [5:0] cnt;
    bit         chk_cnt;
  } exp_t;

  typedef struct {
    int          nbits;
    logic [63:0] data;
    int          gap;
    logic [7:0]  cxor;
    logic        ok;
    logic        cerr;
    logic        lerr;
    logic [5:0]  cnt;
  } vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Generator model: CRC register after n data bits, data[0] first.
  function automatic logic [7:0] gen_crc(input logic [63:0] data, input int n);
    logic [7:0] l;
    logic       fb;
    l = SEED;
    for (int k = 0; k < n; k++) begin
      fb = data[k] ^ l[0];
      l  = {fb, l[7:1] ^ (TAPS[6:0] & {7{fb}})};
    end
    return l;
  endfunction

  function automatic exp_t mk(input logic ok, cerr, lerr, input logic [5:0] cnt,
                              input bit chk_cnt);
    exp_t e;
    e.ok = ok; e.cerr = cerr; e.lerr = lerr; e.cnt = cnt; e.chk_cnt = chk_cnt;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One clock cycle of stimulus; outputs sampled 1 time unit after the edge.
  task automatic step(input logic s, input logic d, input logic c, input bit exp_done);
    exp_t e;
    SER_IN = s; DATA_EN = d; CRC_EN = c;
    @(posedge CLK); #1;
    SER_IN = 1'b0; DATA_EN = 1'b0; CRC_EN = 1'b0;
    if (exp_done) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty: got DONE=%b with no queued result", DONE);
      end else begin
        e = q.pop_front();
        chk("done_pulse", {31'd0, DONE}, 32'd1);
        chk("flags_ok_cerr_lerr", {29'd0, CRC_OK, CRC_ERR, LEN_ERR}, {29'd0, e.ok, e.cerr, e.lerr});
        if (e.chk_cnt) chk("data_cnt", {26'd0, DATA_CNT}, {26'd0, e.cnt});
      end
    end else if (DONE !== 1'b0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_done: got DONE=%b expected 0", DONE);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_data(input logic [63:0] data, input int n);
    for (int k = 0; k < n; k++) step(data[k], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_crc(input logic [7:0] crc, input exp_t e);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) q.push_back(e);
      step(crc[k], 1'b0, 1'b1, k == 7);
    end
  endtask

  task automatic send_frame(input logic [63:0] data, input int n, input int gap,
                            input logic [7:0] cxor, input exp_t e);
    send_data(data, n);
    idle(gap);
    send_crc(gen_crc(data, n) ^ cxor, e);
  endtask

  vec_t       vecs[11];
  logic [7:0] t1_crc;
  logic [63:0] d64;

  initial begin
    // ok cerr lerr cnt
    vecs[0]  = '{8,  64'h0,                0,  8'h01, 1'b0, 1'b1, 1'b0, 6'd8};
    vecs[1]  = '{1,  64'h1,                0,  8'h00, 1'b1, 1'b0, 1'b0, 6'd1};
    vecs[2]  = '{16, 64'hA5C3,             2,  8'h00, 1'b1, 1'b0, 1'b0, 6'd16};
    vecs[3]  = '{32, 64'hDEADBEEF,         0,  8'h00, 1'b1, 1'b0, 1'b0, 6'd32};
    vecs[4]  = '{33, 64'h1_2345_6789,      1,  8'h00, 1'b0, 1'b0, 1'b1, 6'd33};
    vecs[5]  = '{40, 64'hC3_9A5F_0E71,     1,  8'h00, 1'b0, 1'b0, 1'b1, 6'd40};
    vecs[6]  = '{64, 64'hFEDC_BA98_7654_3210, 1, 8'h00, 1'b0, 1'b0, 1'b1, 6'd63};
    vecs[7]  = '{12, 64'hABC,              1,  8'h80, 1'b0, 1'b1, 1'b0, 6'd12};
    vecs[8]  = '{20, 64'h5_A5A5,           14, 8'h00, 1'b1, 1'b0, 1'b0, 6'd20};
    vecs[9]  = '{40, 64'h77_1122_3344,     0,  8'h10, 1'b0, 1'b1, 1'b1, 6'd40};
    vecs[10] = '{7,  64'h55,               3,  8'hFF, 1'b0, 1'b1, 1'b0, 6'd7};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs_low", {26'd0, BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR, DATA_CNT[0]},
        32'd0);
    chk("reset_data_cnt", {26'd0, DATA_CNT}, 32'd0);
    RST = 1'b1;
    idle(2);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    // T1 with the literal CRC 0x14
    t1_crc = 8'h14;
    send_data(64'h0, 8);
    chk("busy_in_data", {31'd0, BUSY}, 32'd1);
    idle(1);
    send_crc(t1_crc, mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));
    chk("busy_after_done", {31'd0, BUSY}, 32'd0);

    // Table of whole frames
    foreach (vecs[i])
      send_frame(vecs[i].data, vecs[i].nbits, vecs[i].gap, vecs[i].cxor,
                 mk(vecs[i].ok, vecs[i].cerr, vecs[i].lerr, vecs[i].cnt, 1'b1));

    // Flags hold after the pulse
    idle(3);
    chk("flags_hold", {29'd0, CRC_OK, CRC_ERR, LEN_ERR}, 32'b010);
    chk("cnt_hold", {26'd0, DATA_CNT}, 32'd7);

    // CRC_EN alone in IDLE is ignored
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("crc_en_in_idle_busy", {31'd0, BUSY}, 32'd0);

    // DATA_EN has priority over CRC_EN
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    send_crc(t1_crc, mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));

    // T3: abort after 3 correct CRC bits; dropped bit must not start a frame
    send_data(64'h0, 8);
    for (int k = 0; k < 3; k++) step(t1_crc[k], 1'b0, 1'b1, 1'b0);
    q.push_back(mk(1'b0, 1'b0, 1'b1, 6'd0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    send_frame(64'h0, 8, 1, 8'h00, mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));

    // Abort after a mismatched first CRC bit keeps CRC_ERR
    send_data(64'h0, 8);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    q.push_back(mk(1'b0, 1'b1, 1'b1, 6'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // T4: 14 idle cycles survive, counter clears, frame completes
    d64 = 64'hB6;
    send_data(d64, 4);
    idle(14);
    chk("busy_after_14_idle", {31'd0, BUSY}, 32'd1);
    for (int k = 4; k < 8; k++) step(d64[k], 1'b1, 1'b0, 1'b0);
    idle(1);
    send_crc(gen_crc(d64, 8), mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));

    // T4: 15 idle cycles in DATA time out
    send_data(64'h9, 4);
    idle(14);
    q.push_back(mk(1'b0, 1'b0, 1'b1, 6'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("timeout_busy", {31'd0, BUSY}, 32'd0);

    // Timeout in CHECK reports CRC_ERR=0 even after a mismatch
    send_data(64'h0, 8);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(14);
    q.push_back(mk(1'b0, 1'b0, 1'b1, 6'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // T6: asynchronous reset mid-frame
    send_frame(64'h0, 8, 1, 8'h00, mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));
    send_data(64'h1F, 5);
    #2 RST = 1'b0;
    #1;
    chk("midframe_reset_flags", {27'd0, BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR}, 32'd0);
    chk("midframe_reset_cnt", {26'd0, DATA_CNT}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(2);
    chk("post_reset_busy", {31'd0, BUSY}, 32'd0);

    // T6: two T1 frames back to back
    send_frame(64'h0, 8, 1, 8'h00, mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));
    send_frame(64'h0, 8, 1, 8'h00, mk(1'b1, 1'b0, 1'b0, 6'd8, 1'b1));
    idle(2);

    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_leftover: got %0d queued results expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
